tick_scheduler: RTL
===================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of timer channels. Fixed at 4 for this revision; channel index is 2 bits.
REQ-002 Parameter DW, default 27: delay and counter width.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfg_we  in  1  configuration write strobe, one cycle.
REQ-006 cfg_ch  in  2  channel being configured.
REQ-007 cfg_delay  in  DW  reload value; tick period is cfg_delay+1 cycles.
REQ-008 cfg_run  in  1  channel run enable.
REQ-009 tick  out  NUM_CH  per-channel one-cycle expiry pulse, registered.
REQ-010 evt_valid  out  1  event offered to the consumer.
REQ-011 evt_ch  out  2  channel of the offered event.
REQ-012 evt_ready  in  1  consumer accepts the event.
REQ-013 overrun  out  NUM_CH  sticky flag per channel: an expiry occurred while an event was already pending for that channel.
REQ-014 clr_overrun  in  1  clears all overrun bits.

Function
REQ-015 Each channel holds delay[DW], count[DW], run, pending.
REQ-016 run=1, count==0: assert tick[ch] next cycle; count<=delay; set pending.
REQ-017 run=1, count!=0: count<=count-1. No wrap below 0.
REQ-018 run=0: count holds and no tick is generated. pending and overrun are unaffected.
REQ-019 delay=0 with run=1: tick every cycle.
REQ-020 cfg_we: delay[cfg_ch]<=cfg_delay, count[cfg_ch]<=cfg_delay, run[cfg_ch]<=cfg_run, pending[cfg_ch]<=0.
REQ-021 cfg_we to a channel whose count==0 in the same cycle: the write wins; no tick and no pending set for that channel.
REQ-022 First tick after a write with cfg_run=1 occurs cfg_delay+1 cycles after the write cycle.
REQ-023 Expiry while pending[ch]=1 and not cleared in the same cycle: overrun[ch]<=1; pending stays 1; the tick pulse still fires.
REQ-024 Arbiter FSM has two states, IDLE and OFFER.
REQ-025 IDLE: if any pending bit is set, select the first set bit searching from rr_ptr upward (modulo NUM_CH), latch it into evt_ch, and go to OFFER. evt_valid=1 from the next cycle.
REQ-026 OFFER: evt_valid=1; evt_ch is held stable until the handshake.
REQ-027 OFFER with evt_ready=1: clear pending[evt_ch], rr_ptr<=evt_ch+1 (mod NUM_CH), go to IDLE; evt_valid=0 next cycle.
REQ-028 Throughput is at most one event per 2 cycles; at least one idle cycle separates consecutive events.
REQ-029 Expiry of channel evt_ch in the handshake cycle: pending stays 1 and no overrun is flagged. The new event is re-offered under round-robin.
REQ-030 cfg_we to channel evt_ch while in OFFER clears pending[evt_ch], but the current offer still completes unchanged. Withdrawing an offer is not permitted.
REQ-031 clr_overrun clears all overrun bits. If an overrun is set in the same cycle, the set wins for that bit.
REQ-032 An event is never lost or duplicated except as flagged by overrun.

Reset
REQ-033 reset=1 at a clock edge sets the following to 0 in all channels: delay, count, run, pending, overrun.
REQ-034 The same reset also sets: tick=0, evt_valid=0, evt_ch=0, rr_ptr=0, FSM=IDLE.
REQ-035 Reset mid-offer drops the offered event and all pending events; evt_valid=0 the next cycle.
REQ-036 reset has priority over cfg_we, expiry and handshake.

Verification
REQ-037 Write ch0, delay=3, run=1; hold evt_ready=1 -> tick[0] fires every 4 cycles, first 4 cycles after the write; each tick is followed by evt_valid with evt_ch=0; overrun stays 0.
REQ-038 Channels 0–3 all run with delay=9 and were written in the same cycle; evt_ready=1 -> events are presented in order ch0,1,2,3 in alternating valid/idle cycles; the next round starts from ch0 after rr_ptr wraps.
REQ-039 ch2 runs with delay=1 and evt_ready=0 -> first event is offered; a later tick sets overrun[2]=1; evt_ch holds at 2; pulsing clr_overrun in a non-tick cycle returns overrun[2] to 0.
REQ-040 ch1 runs with delay=0 and evt_ready=1 -> tick[1] fires every cycle; pending stays set across handshakes; overrun[1] is set on ticks that land in non-handshake cycles.
REQ-041 cfg_we to ch3 with run=0 in the cycle ch3's count==0 -> no tick[3], pending[3]=0, and count holds at the new delay.
REQ-042 Assert reset while evt_valid=1 and pending is non-zero -> the next cycle shows all outputs 0; after release with no writes, there is no tick or event for 100 cycles.

Source files
------------

// File: rtl/tick_scheduler.sv
// Four-channel periodic tick generator with a round-robin event offer port.
// Each expiry pulses tick and queues a pending event; repeats while pending flag overrun.
module tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DW     = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_ch,
    input  logic [DW-1:0]     cfg_delay,
    input  logic              cfg_run,
    output logic [NUM_CH-1:0] tick,
    output logic              evt_valid,
    output logic [1:0]        evt_ch,
    input  logic              evt_ready,
    output logic [NUM_CH-1:0] overrun,
    input  logic              clr_overrun
);

    typedef enum logic {IDLE, OFFER} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     delay_q [NUM_CH];
    logic [DW-1:0]     delay_d [NUM_CH];
    logic [DW-1:0]     count_q [NUM_CH];
    logic [DW-1:0]     count_d [NUM_CH];
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [1:0]        evt_ch_q, evt_ch_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0] wr_sel, hs_sel, expire;
    logic              hs;
    logic              found;
    logic [1:0]        idx;

    assign tick      = tick_q;
    assign evt_valid = (state_q == OFFER);
    assign evt_ch    = evt_ch_q;
    assign overrun   = overrun_q;

    always_comb begin
        hs        = (state_q == OFFER) && evt_ready;
        wr_sel    = '0;
        hs_sel    = '0;
        expire    = '0;
        run_d     = run_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        tick_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            delay_d[i] = delay_q[i];
            count_d[i] = count_q[i];
            wr_sel[i]  = cfg_we && (cfg_ch == 2'(i));
            hs_sel[i]  = hs && (evt_ch_q == 2'(i));
            // A write to the channel pre-empts its own expiry.
            expire[i]  = run_q[i] && (count_q[i] == '0) && !wr_sel[i];
            tick_d[i]  = expire[i];
            if (wr_sel[i]) begin
                delay_d[i] = cfg_delay;
                count_d[i] = cfg_delay;
                run_d[i]   = cfg_run;
            end else if (expire[i]) begin
                count_d[i] = delay_q[i];
            end else if (run_q[i]) begin
                count_d[i] = count_q[i] - 1'b1;
            end
            if (wr_sel[i]) begin
                pending_d[i] = 1'b0;
            end else if (expire[i]) begin
                pending_d[i] = 1'b1;
            end else if (hs_sel[i]) begin
                pending_d[i] = 1'b0;
            end
            overrun_d[i] = (overrun_q[i] && !clr_overrun)
                         || (expire[i] && pending_q[i] && !hs_sel[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        evt_ch_d = evt_ch_q;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    idx = rr_ptr_q + 2'(k);
                    if (!found && pending_q[idx]) begin
                        found    = 1'b1;
                        evt_ch_d = idx;
                        state_d  = OFFER;
                    end
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = evt_ch_q + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            run_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            tick_q    <= '0;
            evt_ch_q  <= '0;
            rr_ptr_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                delay_q[i] <= '0;
                count_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            tick_q    <= tick_d;
            evt_ch_q  <= evt_ch_d;
            rr_ptr_q  <= rr_ptr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                delay_q[i] <= delay_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

endmodule
